// File: rtl/line_fetch.sv
// Line fetcher: splits a word-addressed line into row-safe bursts of up to 4 words
// and streams the read data through a credit-guarded FWFT FIFO. Optional macro: LINE_FETCH_ABORT_EN.
module line_fetch #(
  parameter int DEPTH    = 64,
  parameter int MAXWORDS = 2048
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic [22:0] base_i,
  input  logic [11:0] nwords_i,
`ifdef LINE_FETCH_ABORT_EN
  input  logic        abort_i,
`endif
  output logic        busy_o,
  output logic        done_o,
  output logic [22:0] memaddr_o,
  output logic [1:0]  memlen_o,
  output logic        memwr_o,
  output logic        memreq_o,
  input  logic        memready_i,
  input  logic        memack_i,
  input  logic [31:0] memrdata_i,
  output logic [31:0] outdata_o,
  output logic        outvalid_o,
  input  logic        outready_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [11:0] MAXLEN  = 12'(MAXWORDS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [22:0]     addr_q, addr_d;
  logic [11:0]     rem_q, rem_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic            done_q, done_d;
  logic            disc_q, disc_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_q;
  logic [31:0]     pend_data_q;
  logic [31:0]     mem [DEPTH];

  logic [8:0]      row_left;
  logic [2:0]      blen, blen_m1;
  logic [CW:0]     used;
  logic            credit_ok, accept, ack_take, push, pop, flush, wr_en, abort_now;
  logic [11:0]     len_in;
  logic [CW-1:0]   inc, dec;

`ifdef LINE_FETCH_ABORT_EN
  assign abort_now = abort_i && (state_q != IDLE);
`else
  assign abort_now = 1'b0;
`endif

  // Burst length: at most 4, never past the line end or the current 256-word row.
  always_comb begin
    row_left = 9'd256 - {1'b0, addr_q[7:0]};
    blen     = (rem_q >= 12'd4) ? 3'd4 : rem_q[2:0];
    if ({6'd0, blen} > row_left) blen = row_left[2:0];
    blen_m1  = blen - 3'd1;
  end

  // Words already in flight or buffered reserve FIFO space, so overflow cannot happen.
  assign used      = {1'b0, cnt_q} + {{CW{1'b0}}, pend_q} + {1'b0, outst_q};
  assign credit_ok = (DEPTH_W - used) >= {{(CW-2){1'b0}}, blen};

  assign memreq_o  = (state_q == ISSUE) && (blen != 3'd0) && credit_ok;
  assign memaddr_o = addr_q;
  assign memlen_o  = (state_q == ISSUE) ? blen_m1[1:0] : 2'd0;
  assign memwr_o   = 1'b0;

  assign accept   = memreq_o && memready_i;
  assign ack_take = memack_i && (outst_q != '0);
  assign flush    = abort_now;
  assign push     = ack_take && !disc_q && !flush;
  assign pop      = (cnt_q != '0) && outready_i && !flush;
  assign wr_en    = pend_q && !flush;
  assign len_in   = (nwords_i > MAXLEN) ? MAXLEN : nwords_i;
  assign inc      = accept ? {{(CW-3){1'b0}}, blen} : '0;
  assign dec      = ack_take ? {{(CW-1){1'b0}}, 1'b1} : '0;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    disc_d  = disc_q;
    outst_d = outst_q + inc - dec;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_in == 12'd0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = base_i;
            rem_d   = len_in;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (accept) begin
          addr_d = addr_q + {20'd0, blen};
          rem_d  = rem_q - {9'd0, blen};
          if (rem_q == {9'd0, blen}) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (outst_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          disc_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_now && (state_q == ISSUE)) state_d = DRAIN;
    if (abort_now && (state_d != IDLE)) disc_d = 1'b1;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + (wr_en ? {{(AW-1){1'b0}}, 1'b1} : '0);
    rd_ptr_d = rd_ptr_q + (pop ? {{(AW-1){1'b0}}, 1'b1} : '0);
    cnt_d    = cnt_q + {{(CW-1){1'b0}}, wr_en} - {{(CW-1){1'b0}}, pop};
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      outst_q     <= '0;
      done_q      <= 1'b0;
      disc_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      outst_q  <= outst_d;
      done_q   <= done_d;
      disc_q   <= disc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      pend_q   <= push;
      if (push) pend_data_q <= memrdata_i;
    end
  end

  // Ack data is staged one cycle before it lands in storage.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= pend_data_q;
  end

  assign outdata_o  = mem[rd_ptr_q];
  assign outvalid_o = (cnt_q != '0);
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
endmodule

// File: tb/tb_line_fetch.sv
// Directed bench for line_fetch (DEPTH=8) with a fixed-latency memory model and an output consumer.
module tb_line_fetch;
  localparam int DEPTH = 8;

  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [22:0] base = '0;
  logic [11:0] nwords = '0;
`ifdef LINE_FETCH_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic        busy, done, memwr, memreq, outvalid;
  logic        memready = 1'b1, memack = 1'b0, outready = 1'b1;
  logic [22:0] memaddr;
  logic [1:0]  memlen;
  logic [31:0] memrdata = '0, outdata;

  int n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  line_fetch #(.DEPTH(DEPTH), .MAXWORDS(2048)) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .base_i(base), .nwords_i(nwords),
`ifdef LINE_FETCH_ABORT_EN
    .abort_i(abort),
`endif
    .busy_o(busy), .done_o(done), .memaddr_o(memaddr), .memlen_o(memlen),
    .memwr_o(memwr), .memreq_o(memreq), .memready_i(memready), .memack_i(memack),
    .memrdata_i(memrdata), .outdata_o(outdata), .outvalid_o(outvalid), .outready_i(outready)
  );

  int          neg_cnt = 0;
  logic [22:0] wq_addr[$];
  int          wq_rdy[$];
  logic [22:0] rq_addr[$];
  logic [1:0]  rq_len[$];
  logic [31:0] got[$];
  int          done_cnt = 0, req_hi = 0, ov_cnt = 0;

  function automatic logic [31:0] word_of(input logic [22:0] a);
    return {9'h15A, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
    end else begin
      $display("ok   %s: %h", tag, got_v);
    end
  endtask

  // Memory model (acks 3 edges after accept, one per cycle) and output consumer.
  initial forever begin
    @(negedge clk);
    neg_cnt++;
    if (memreq && memready) begin
      rq_addr.push_back(memaddr);
      rq_len.push_back(memlen);
      for (int i = 0; i <= int'(memlen); i++) begin
        wq_addr.push_back(memaddr + 23'(i));
        wq_rdy.push_back(neg_cnt + 3);
      end
    end
    if (memreq) req_hi++;
    if (outvalid) ov_cnt++;
    if (outvalid && outready) got.push_back(outdata);
    if (done) done_cnt++;
    memack = 1'b0;
    if (wq_addr.size() > 0 && wq_rdy[0] <= neg_cnt) begin
      memack   = 1'b1;
      memrdata = word_of(wq_addr.pop_front());
      void'(wq_rdy.pop_front());
    end
  end

  task automatic start_line(input logic [22:0] b, input logic [11:0] n);
    rq_addr.delete(); rq_len.delete(); got.delete();
    done_cnt = 0; req_hi = 0; ov_cnt = 0;
    @(posedge clk); #1;
    base = b; nwords = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (done_cnt == 0 && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    if (done_cnt == 0) check("done_timeout", 32'(c), 32'(budget + 1));
    repeat (6) begin @(posedge clk); #1; end
  endtask

  task automatic expect_req(input int i, input logic [22:0] a, input logic [1:0] l);
    if (i < rq_addr.size()) begin
      check("req_addr", 32'(rq_addr[i]), 32'(a));
      check("req_len", 32'(rq_len[i]), 32'(l));
    end else begin
      check("req_missing", 32'(rq_addr.size()), 32'(i + 1));
    end
  endtask

  task automatic check_words(input logic [22:0] b, input int n);
    logic [22:0] a;
    check("word_count", 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++) begin
      a = b + 23'(i);
      check("word_data", got[i], word_of(a));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int total;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_memreq", 32'(memreq), 0);
    check("rst_outvalid", 32'(outvalid), 0);
    check("rst_memaddr", 32'(memaddr), 0);
    check("rst_memlen", 32'(memlen), 0);
    check("rst_memwr", 32'(memwr), 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Aligned line of 10 words
    start_line(23'h000100, 12'd10);
    check("t1_busy", 32'(busy), 1);
    check("t1_first_req", 32'(memreq), 1);
    check("t1_first_addr", 32'(memaddr), 32'h100);
    wait_done(200);
    check("t1_nreq", 32'(rq_addr.size()), 3);
    expect_req(0, 23'h000100, 2'd3);
    expect_req(1, 23'h000104, 2'd3);
    expect_req(2, 23'h000108, 2'd1);
    check_words(23'h000100, 10);
    check("t1_done_cnt", 32'(done_cnt), 1);
    check("t1_idle", 32'(busy), 0);

    // Row boundary split
    start_line(23'h0000FE, 12'd6);
    wait_done(200);
    check("t2_nreq", 32'(rq_addr.size()), 2);
    expect_req(0, 23'h0000FE, 2'd1);
    expect_req(1, 23'h000100, 2'd3);
    check_words(23'h0000FE, 6);

    // Zero-length line
    start_line(23'h000200, 12'd0);
    check("t3_done_next", 32'(done), 1);
    check("t3_busy_low", 32'(busy), 0);
    repeat (4) begin @(posedge clk); #1; end
    check("t3_no_req", 32'(req_hi), 0);
    check("t3_done_cnt", 32'(done_cnt), 1);

    // Address wrap at 2^23
    start_line(23'h7FFFFE, 12'd4);
    wait_done(200);
    expect_req(0, 23'h7FFFFE, 2'd1);
    expect_req(1, 23'h000000, 2'd1);
    check_words(23'h7FFFFE, 4);

    // Backpressure: FIFO credit limits requests to DEPTH words
    outready = 1'b0;
    start_line(23'h000500, 12'd20);
    repeat (40) begin @(posedge clk); #1; end
    total = 0;
    foreach (rq_len[i]) total += int'(rq_len[i]) + 1;
    check("t5_words_req", 32'(total), DEPTH);
    check("t5_memreq_low", 32'(memreq), 0);
    check("t5_outvalid", 32'(outvalid), 1);
    check("t5_busy", 32'(busy), 1);
    base = 23'h000007; nwords = 12'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    outready = 1'b1;
    wait_done(400);
    check_words(23'h000500, 20);
    check("t5_done_cnt", 32'(done_cnt), 1);

    // Reset with 4 words outstanding
    start_line(23'h000200, 12'd16);
    @(posedge clk); #1;
    memready = 1'b0;
    rstn = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 0);
    check("t6_memreq", 32'(memreq), 0);
    check("t6_memaddr", 32'(memaddr), 0);
    check("t6_outvalid", 32'(outvalid), 0);
    ov_cnt = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    memready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("t6_stale_ignored", 32'(ov_cnt), 0);
    check("t6_still_idle", 32'(busy), 0);
    start_line(23'h000300, 12'd5);
    wait_done(200);
    expect_req(0, 23'h000300, 2'd3);
    expect_req(1, 23'h000304, 2'd0);
    check_words(23'h000300, 5);

`ifdef LINE_FETCH_ABORT_EN
    // Abort after the first accepted burst
    start_line(23'h000400, 12'd16);
    @(posedge clk); #1;
    abort = 1'b1;
    memready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t7_memreq_dropped", 32'(memreq), 0);
    memready = 1'b1;
    wait_done(200);
    check("t7_nreq", 32'(rq_addr.size()), 1);
    check("t7_no_output", 32'(ov_cnt), 0);
    check("t7_done_cnt", 32'(done_cnt), 1);
    check("t7_idle", 32'(busy), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/line_fetch.md
LINE_FETCH -- requirements
Module: line_fetch

Interface
REQ-001 Parameter DEPTH, default 64, output FIFO depth in 32-bit words, power of two, 8..256.
REQ-002 Parameter MAXWORDS, default 2048, largest line length accepted on nwords.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rstn  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  one-cycle pulse; begins a line fetch when idle.
REQ-006 base  in  23  first word address of the line, sampled on accepted start.
REQ-007 nwords  in  12  line length in words, sampled on accepted start.
REQ-008 busy  out  1  high from accepted start until done.
REQ-009 done  out  1  one-cycle pulse when line complete.
REQ-010 memaddr  out  23  controller port word address.
REQ-011 memlen  out  2  burst length minus one.
REQ-012 memwr  out  1  tied 0; read-only client.
REQ-013 memreq  out  1  request valid.
REQ-014 memready  in  1  controller port can accept a request.
REQ-015 memack  in  1  one read word valid on memrdata this cycle.
REQ-016 memrdata  in  32  read data.
REQ-017 outdata  out  32  FIFO head word.
REQ-018 outvalid  out  1  FIFO non-empty.
REQ-019 outready  in  1  consumer pop.

Function
REQ-020 States IDLE, ISSUE, DRAIN; IDLE->ISSUE on start with nwords!=0; ISSUE->DRAIN when remaining-to-request=0; DRAIN->IDLE when outstanding=0, pulsing done.
REQ-021 start with nwords=0: done pulses the next cycle, no request issued, busy stays low.
REQ-022 start while busy is ignored.
REQ-023 Burst words L = min(4, remaining, 256-addr[7:0]); memlen=L-1; bursts never cross a 256-word row.
REQ-024 memreq asserted only when DEPTH - fifocount - outstanding >= L; FIFO overflow is impossible by construction.
REQ-025 Request accepted on a cycle with memreq&&memready; memaddr/memlen held stable while memreq high and not accepted.
REQ-026 On acceptance: addr += L, remaining -= L, outstanding += L; a new request may be presented the following cycle.
REQ-027 Each memack pushes memrdata into FIFO and decrements outstanding; simultaneous accept and ack update outstanding by L-1.
REQ-028 First memreq is high the cycle after the accepted start.
REQ-029 FIFO is first-word-fall-through; a word pushed at edge N is visible with outvalid after edge N+1 (data registered one cycle).
REQ-030 Pop on outvalid&&outready; push and pop in the same cycle leave the count unchanged; pop when empty has no effect.
REQ-031 Words leave the FIFO in address order.
REQ-032 Address arithmetic wraps modulo 2^23.

Reset
REQ-033 rstn low: state IDLE; busy, done, memreq, outvalid = 0; FIFO empty; outstanding = 0; memaddr/memlen = 0.
REQ-034 Reset mid-line abandons the fetch; acks arriving after release while IDLE are discarded.

Configuration
REQ-035 Macro LINE_FETCH_ABORT_EN defined: adds input abort (1 bit); abort in ISSUE/DRAIN stops new requests (memreq drops next cycle unless accepted same cycle), flushes FIFO, discards remaining acks, enters DRAIN, pulses done when outstanding=0.
REQ-036 Macro undefined: no abort port, no abort logic; behaviour per REQ-020..032.

Verification
REQ-037 base=0x000100, nwords=10, memready always 1, acks 3 cycles after accept -> requests (0x100,len3),(0x104,len3),(0x108,len1); 10 words out in order; one done pulse.
REQ-038 base=0x0000FE, nwords=6 -> requests (0xFE,len1),(0x100,len3); no row crossing.
REQ-039 DEPTH=8, outready=0, nwords=20 -> exactly 8 words requested, memreq stays low; set outready=1 -> fetch resumes, all 20 delivered.
REQ-040 start with nwords=0 -> done next cycle, memreq never high.
REQ-041 rstn pulsed low while 4 words outstanding -> outputs zero immediately; later acks ignored; next start fetches correctly.
REQ-042 With LINE_FETCH_ABORT_EN: abort after first accept of nwords=16 -> no further requests, outvalid 0, done after last ack of that burst.
